// File: rtl/div_dp.sv
// div_dp: sequential restoring shift-subtract divider with its own WAIT/CALC/DONE
// control and a start/done handshake. Produces quotient and remainder WIDTH+1
// cycles after an accepted start, or 1 cycle after an accepted divide-by-zero.
// Optional feature: define SIGNED_DIV_EN for two's-complement operands
// (magnitudes are divided, then the quotient and remainder signs are restored).
module div_dp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             divByZero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;        // partial remainder (always < divisor)
    logic [WIDTH-1:0] dvd_q;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;        // latched divisor magnitude
    logic [CW-1:0]    cnt_q;        // iterations remaining minus one
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   shift_s;      // shifted partial remainder, one bit wider
    logic             ge_s;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

`ifdef SIGNED_DIV_EN
    logic flip_a_q;
    logic flip_b_q;

    // Two's-complement negation of an operand-width value.
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes and sign restoration of the finished result.
    always_comb begin
        a_mag_s = A[WIDTH-1] ? neg_f(A) : A;
        b_mag_s = B[WIDTH-1] ? neg_f(B) : B;
        if (flip_a_q ^ flip_b_q) begin
            q_fix_s = neg_f(dvd_q);
        end else begin
            q_fix_s = dvd_q;
        end
        if (flip_a_q) begin
            r_fix_s = neg_f(rem_q);
        end else begin
            r_fix_s = rem_q;
        end
    end
`else
    // Unsigned operation: operands and results pass straight through.
    always_comb begin
        a_mag_s = A;
        b_mag_s = B;
        q_fix_s = dvd_q;
        r_fix_s = rem_q;
    end
`endif

    // One restoring iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shift_s = {rem_q, dvd_q[WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_d = WIDTH'(shift_s - {1'b0, dvs_q});
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shift_s[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= WAIT;
            rem_q       <= {WIDTH{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            flip_a_q    <= 1'b0;
            flip_b_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                WAIT: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (B == {WIDTH{1'b0}}) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            dbz_q   <= 1'b1;
                            dvd_q   <= {WIDTH{1'b1}};
                            rem_q   <= A;
`ifdef SIGNED_DIV_EN
                            flip_a_q <= 1'b0;
                            flip_b_q <= 1'b0;
`endif
                            state_q <= DONE;
                        end else begin
                            dbz_q   <= 1'b0;
                            dvd_q   <= a_mag_s;
                            dvs_q   <= b_mag_s;
                            rem_q   <= {WIDTH{1'b0}};
                            cnt_q   <= CW'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
                            flip_a_q <= A[WIDTH-1];
                            flip_b_q <= B[WIDTH-1];
`endif
                            state_q <= CALC;
                        end
                    end else begin
                        state_q <= WAIT;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    // Internal registers are frozen here, so outputs stay stable.
                    quotient_q  <= q_fix_s;
                    remainder_q <= r_fix_s;
                    if (start) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= WAIT;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_div_dp.sv
// Self-checking bench for div_dp (WIDTH=8): directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_dp;

    localparam int W = 8;

    logic         clk;
    logic         reset_L;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         divByZero;

    int checks = 0;
    int errors = 0;

    div_dp #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .A         (A),
        .B         (B),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef SIGNED_DIV_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            q = '1;
            r = a;
        end else if (sa == -(1 << (W - 1)) && sb == -1) begin
            q = a;
            r = '0;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
`else
        int ua;
        int ub;
        ua = int'(a);
        ub = int'(b);
        if (ub == 0) begin
            q = '1;
            r = a;
        end else begin
            q = W'(ua / ub);
            r = W'(ua % ub);
        end
`endif
    endfunction

    // One complete handshake: start, wait for done, check results, drop start.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int lat;
        int exp_lat;
        ref_div(a, b, eq, er);
        exp_lat = (b == '0) ? 1 : W + 1;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("done_low_at_accept", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 40) begin
            if (scramble) begin
                A = W'($urandom);
                B = W'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("divByZero", 32'(divByZero), 32'(b == '0));
        if (scramble) begin
            A = W'($urandom);
            B = W'($urandom);
        end
        @(posedge clk);
        #1;
        chk("done_held", 32'(done), 32'd1);
        chk("quotient_held", 32'(quotient), 32'(eq));
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", 32'(done), 32'd0);
        chk("quotient_after", 32'(quotient), 32'(eq));
        chk("remainder_after", 32'(remainder), 32'(er));
    endtask

    initial begin
        reset_L = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(divByZero), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;

        // Idle with start low: nothing happens.
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);

        // Directed cases.
        do_op(8'd200, 8'd7, 1'b0);
        do_op(8'd255, 8'd1, 1'b0);
        do_op(8'h05, 8'hFF, 1'b0);
        do_op(8'd5, 8'd0, 1'b0);
        do_op(8'd9, 8'd3, 1'b0);
        do_op(8'd3, 8'd200, 1'b0);
        do_op(8'd255, 8'd128, 1'b0);
`ifdef SIGNED_DIV_EN
        do_op(8'h9C, 8'd7, 1'b0);
        do_op(8'h80, 8'hFF, 1'b0);
        do_op(8'h64, 8'hF9, 1'b0);
        do_op(8'h80, 8'h00, 1'b0);
`else
        chk("const_q_200_7", 32'(W'(200 / 7)), 32'd28);
`endif

        // Reset mid-calculation aborts everything.
        @(negedge clk);
        A = 8'd200;
        B = 8'd3;
        start = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        reset_L = 1'b0;
        start = 1'b0;
        #1;
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dbz", 32'(divByZero), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        do_op(8'd100, 8'd10, 1'b0);

        // Randomized operations with operand toggling during CALC/DONE.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_op(ra, rb, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
